// File: rtl/quant_scheduler_pkg.sv
// Shared constants for the quantizer scheduler: component codes, FSM states,
// and the MCU slot-to-component tables for 4:2:0 and 4:4:4 ordering.
package quant_scheduler_pkg;

    localparam int TIMER_W = 7;
    localparam int SLOT_W  = 3;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_REQ  = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        OUT       = 3'd4
    } state_t;

    // Entry 0 is the rightmost element; unused entries are padding for a clean 3-bit index.
    localparam logic [7:0][1:0] SLOT_COMP_420 =
        {COMP_Y, COMP_Y, COMP_CR, COMP_CB, COMP_Y, COMP_Y, COMP_Y, COMP_Y};
    localparam logic [7:0][1:0] SLOT_COMP_444 =
        {COMP_Y, COMP_Y, COMP_Y, COMP_Y, COMP_Y, COMP_CR, COMP_CB, COMP_Y};

    function automatic comp_t slot_comp(input logic [SLOT_W-1:0] s, input logic s420);
        return comp_t'(s420 ? SLOT_COMP_420[s] : SLOT_COMP_444[s]);
    endfunction

    function automatic logic [SLOT_W-1:0] last_slot(input logic s420);
        return s420 ? 3'd5 : 3'd2;
    endfunction

endpackage

// File: rtl/quant_scheduler_if.sv
// Handshake bundle between the scheduler, the component producers,
// the shared quantizer and the zigzag stage.
interface quant_scheduler_if;
    logic       y_valid, cb_valid, cr_valid;
    logic       y_ready, cb_ready, cr_ready;
    logic       q_start;
    logic [1:0] q_sel;
    logic       q_done;
    logic       out_valid;
    logic [1:0] out_comp;
    logic       out_ready;
    logic [2:0] slot;
    logic       mcu_done, busy, err;

    modport master (
        input  y_valid, cb_valid, cr_valid, q_done, out_ready,
        output y_ready, cb_ready, cr_ready, q_start, q_sel,
               out_valid, out_comp, slot, mcu_done, busy, err
    );

    modport slave (
        output y_valid, cb_valid, cr_valid, q_done, out_ready,
        input  y_ready, cb_ready, cr_ready, q_start, q_sel,
               out_valid, out_comp, slot, mcu_done, busy, err
    );
endinterface

// File: rtl/quant_watchdog.sv
// Saturating cycle timer for the quantizer wait; counts from 1 on the first
// WAIT_DONE cycle and flags expiry once TIMEOUT cycles have elapsed.
module quant_watchdog
    import quant_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (load) begin
            timer <= TIMER_W'(1);
        end else if (run) begin
            if (timer != '1) timer <= timer + TIMER_W'(1);
        end else begin
            timer <= '0;
        end
    end

    assign expired = run && (timer >= LIMIT);
endmodule

// File: rtl/quant_scheduler.sv
// Arbitrates Y/Cb/Cr blocks into one shared quantizer in MCU slot order,
// launches it, waits for completion with a watchdog, and hands off downstream.
module quant_scheduler
    import quant_scheduler_pkg::*;
#(
    parameter bit SUBSAMPLE_420 = 1'b1,
    parameter int TIMEOUT       = 64
) (
    input logic               clk,
    input logic               rst,
    quant_scheduler_if.master bus
);
    localparam logic [SLOT_W-1:0] LAST = last_slot(SUBSAMPLE_420);

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt, slot_inc;
    comp_t             q_sel, owner;
    logic              owner_valid, accept, expired, set_err, wrap;
    logic              mcu_done, err;

    assign owner = slot_comp(slot, SUBSAMPLE_420);

    always_comb begin
        owner_valid = 1'b0;
        case (owner)
            COMP_Y:  owner_valid = bus.y_valid;
            COMP_CB: owner_valid = bus.cb_valid;
            COMP_CR: owner_valid = bus.cr_valid;
            default: owner_valid = 1'b0;
        endcase
    end

    assign accept   = (state == WAIT_REQ) && owner_valid;
    assign slot_inc = (slot == LAST) ? '0 : slot + SLOT_W'(1);

    quant_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (state == LAUNCH),
        .run     (state == WAIT_DONE),
        .expired (expired)
    );

    // A q_done arriving outside WAIT_DONE is stray (e.g. from a block discarded by reset).
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        set_err   = bus.q_done && (state != WAIT_DONE);
        wrap      = 1'b0;
        case (state)
            IDLE:      state_nxt = WAIT_REQ;
            WAIT_REQ:  if (accept) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.q_done) begin
                    state_nxt = OUT;
                end else if (expired) begin
                    set_err   = 1'b1;
                    slot_nxt  = slot_inc;
                    state_nxt = WAIT_REQ;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    slot_nxt  = slot_inc;
                    wrap      = (slot == LAST);
                    state_nxt = WAIT_REQ;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            slot     <= '0;
            q_sel    <= COMP_Y;
            err      <= 1'b0;
            mcu_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            mcu_done <= wrap;
            if (accept)  q_sel <= owner;
            if (set_err) err   <= 1'b1;
        end
    end

    assign bus.y_ready   = (state == WAIT_REQ) && (owner == COMP_Y);
    assign bus.cb_ready  = (state == WAIT_REQ) && (owner == COMP_CB);
    assign bus.cr_ready  = (state == WAIT_REQ) && (owner == COMP_CR);
    assign bus.q_start   = (state == LAUNCH);
    assign bus.q_sel     = q_sel;
    assign bus.out_valid = (state == OUT);
    assign bus.out_comp  = q_sel;
    assign bus.slot      = slot;
    assign bus.mcu_done  = mcu_done;
    assign bus.busy      = (state == LAUNCH) || (state == WAIT_DONE) || (state == OUT);
    assign bus.err       = err;
endmodule
